// File: rtl/div_sqrt_issue_mvp.sv
// div_sqrt_issue_mvp: valid/ready issue sequencer for the non-restoring div/sqrt core.
// Define DIV_SQRT_ISSUE_TIMEOUT_EN to add the BUSY watchdog and the Out_err_SO port.
module div_sqrt_issue_mvp #(
  parameter int C_MANT_W  = 53,
  parameter int C_EXP_W   = 12,
  parameter int C_MANTZ_W = 57,
  parameter int C_EXPZ_W  = 13,
  parameter int C_PC_W    = 6,
  parameter int C_TAG_W   = 4,
  parameter int C_TIMEOUT = 255
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 Flush_SI,
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic                 In_div_SI,
  input  logic                 In_special_SBI,
  input  logic [C_MANT_W-1:0]  In_mant_a_DI,
  input  logic [C_MANT_W-1:0]  In_mant_b_DI,
  input  logic [C_EXP_W-1:0]   In_exp_a_DI,
  input  logic [C_EXP_W-1:0]   In_exp_b_DI,
  input  logic [1:0]           In_format_DI,
  input  logic [C_PC_W-1:0]    In_prec_DI,
  input  logic [C_TAG_W-1:0]   In_tag_DI,
  output logic                 Core_start_SO,
  output logic                 Core_div_start_SO,
  output logic                 Core_sqrt_start_SO,
  output logic                 Core_kill_SO,
  output logic                 Core_special_SBO,
  output logic                 Core_special_dly_SBO,
  output logic [C_MANT_W-1:0]  Core_mant_a_DO,
  output logic [C_MANT_W-1:0]  Core_mant_b_DO,
  output logic [C_EXP_W-1:0]   Core_exp_a_DO,
  output logic [C_EXP_W-1:0]   Core_exp_b_DO,
  output logic [1:0]           Core_format_DO,
  output logic [C_PC_W-1:0]    Core_prec_DO,
  input  logic                 Core_ready_SI,
  input  logic                 Core_done_SI,
  input  logic [C_MANTZ_W-1:0] Core_mant_z_DI,
  input  logic [C_EXPZ_W-1:0]  Core_exp_z_DI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [C_MANTZ_W-1:0] Out_mant_z_DO,
  output logic [C_EXPZ_W-1:0]  Out_exp_z_DO,
  output logic [C_TAG_W-1:0]   Out_tag_DO,
  output logic                 Out_special_SO,
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
  output logic                 Out_err_SO,
`endif
  output logic [7:0]           Out_lat_DO
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;
  state_t state;
  logic accept;
  logic [7:0] lat_inc;
  assign In_ready_SO = Core_ready_SI & ~Flush_SI & ((state == IDLE) | ((state == HOLD) & Out_ready_SI));
  assign accept = In_valid_SI & In_ready_SO;
  assign lat_inc = (Out_lat_DO == 8'hff) ? Out_lat_DO : Out_lat_DO + 8'd1;
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state <= IDLE;
      Core_start_SO <= 1'b0;
      Core_div_start_SO <= 1'b0;
      Core_sqrt_start_SO <= 1'b0;
      Core_kill_SO <= 1'b0;
      Core_special_SBO <= 1'b1;
      Core_special_dly_SBO <= 1'b1;
      Core_mant_a_DO <= '0;
      Core_mant_b_DO <= '0;
      Core_exp_a_DO <= '0;
      Core_exp_b_DO <= '0;
      Core_format_DO <= '0;
      Core_prec_DO <= '0;
      Out_valid_SO <= 1'b0;
      Out_mant_z_DO <= '0;
      Out_exp_z_DO <= '0;
      Out_tag_DO <= '0;
      Out_special_SO <= 1'b0;
      Out_lat_DO <= '0;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
      Out_err_SO <= 1'b0;
`endif
    end else begin
      Core_start_SO <= 1'b0;
      Core_div_start_SO <= 1'b0;
      Core_sqrt_start_SO <= 1'b0;
      Core_kill_SO <= 1'b0;
      Core_special_dly_SBO <= Core_special_SBO;
      if (Flush_SI) begin
        state <= IDLE;
        Out_valid_SO <= 1'b0;
        Core_kill_SO <= (state == ISSUE) | (state == BUSY);
      end else if (accept) begin
        Core_mant_a_DO <= In_mant_a_DI;
        Core_mant_b_DO <= In_mant_b_DI;
        Core_exp_a_DO <= In_exp_a_DI;
        Core_exp_b_DO <= In_exp_b_DI;
        Core_format_DO <= In_format_DI;
        Core_prec_DO <= In_prec_DI;
        Core_special_SBO <= In_special_SBI;
        Out_tag_DO <= In_tag_DI;
        Out_lat_DO <= '0;
        Out_special_SO <= ~In_special_SBI;
        Out_valid_SO <= ~In_special_SBI;
        state <= In_special_SBI ? ISSUE : HOLD;
        Core_start_SO <= In_special_SBI;
        Core_div_start_SO <= In_special_SBI & In_div_SI;
        Core_sqrt_start_SO <= In_special_SBI & ~In_div_SI;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
        Out_err_SO <= 1'b0;
`endif
        // Special-case bypass returns a zero result without touching the core
        if (!In_special_SBI) begin
          Out_mant_z_DO <= '0;
          Out_exp_z_DO <= '0;
        end
      end else begin
        case (state)
          ISSUE: state <= BUSY;
          BUSY: begin
            Out_lat_DO <= lat_inc;
            if (Core_done_SI) begin
              state <= HOLD;
              Out_valid_SO <= 1'b1;
              Out_mant_z_DO <= Core_mant_z_DI;
              Out_exp_z_DO <= Core_exp_z_DI;
            end
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
            else if (lat_inc == 8'(C_TIMEOUT)) begin
              state <= HOLD;
              Out_valid_SO <= 1'b1;
              Out_mant_z_DO <= '1;
              Out_exp_z_DO <= '0;
              Out_err_SO <= 1'b1;
              Core_kill_SO <= 1'b1;
            end
`endif
          end
          HOLD: begin
            if (Out_ready_SI) begin
              state <= IDLE;
              Out_valid_SO <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_sqrt_issue_mvp.sv
// tb_div_sqrt_issue_mvp: table-driven bench with a behavioural core model and result scoreboard.
module tb_div_sqrt_issue_mvp;
  localparam int MW = 53, EW = 12, MZW = 57, EZW = 13, PW = 6, TW = 4;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 255;
`endif
  typedef struct {
    logic div; logic sp; logic [MW-1:0] ma; logic [MW-1:0] mb;
    logic [EW-1:0] ea; logic [EW-1:0] eb; logic [TW-1:0] tag; int lat;
    logic [MZW-1:0] mz; logic [EZW-1:0] ez;
  } vec_t;
  typedef struct {
    logic [MZW-1:0] mz; logic [EZW-1:0] ez; logic [TW-1:0] tag; logic sp; logic [7:0] lat;
  } exp_t;

  logic Clk_CI = 0, Rst_RBI, Flush_SI, In_valid_SI, In_ready_SO, In_div_SI, In_special_SBI;
  logic [MW-1:0] In_mant_a_DI, In_mant_b_DI, Core_mant_a_DO, Core_mant_b_DO;
  logic [EW-1:0] In_exp_a_DI, In_exp_b_DI, Core_exp_a_DO, Core_exp_b_DO;
  logic [1:0] In_format_DI, Core_format_DO;
  logic [PW-1:0] In_prec_DI, Core_prec_DO;
  logic [TW-1:0] In_tag_DI, Out_tag_DO;
  logic Core_start_SO, Core_div_start_SO, Core_sqrt_start_SO, Core_kill_SO;
  logic Core_special_SBO, Core_special_dly_SBO, Core_ready_SI, Core_done_SI;
  logic [MZW-1:0] Core_mant_z_DI, Out_mant_z_DO;
  logic [EZW-1:0] Core_exp_z_DI, Out_exp_z_DO;
  logic Out_valid_SO, Out_ready_SI, Out_special_SO;
  logic [7:0] Out_lat_DO;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
  logic Out_err_SO;
`endif

  div_sqrt_issue_mvp #(.C_TIMEOUT(TO)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Flush_SI(Flush_SI),
    .In_valid_SI(In_valid_SI), .In_ready_SO(In_ready_SO), .In_div_SI(In_div_SI),
    .In_special_SBI(In_special_SBI), .In_mant_a_DI(In_mant_a_DI), .In_mant_b_DI(In_mant_b_DI),
    .In_exp_a_DI(In_exp_a_DI), .In_exp_b_DI(In_exp_b_DI), .In_format_DI(In_format_DI),
    .In_prec_DI(In_prec_DI), .In_tag_DI(In_tag_DI),
    .Core_start_SO(Core_start_SO), .Core_div_start_SO(Core_div_start_SO),
    .Core_sqrt_start_SO(Core_sqrt_start_SO), .Core_kill_SO(Core_kill_SO),
    .Core_special_SBO(Core_special_SBO), .Core_special_dly_SBO(Core_special_dly_SBO),
    .Core_mant_a_DO(Core_mant_a_DO), .Core_mant_b_DO(Core_mant_b_DO),
    .Core_exp_a_DO(Core_exp_a_DO), .Core_exp_b_DO(Core_exp_b_DO),
    .Core_format_DO(Core_format_DO), .Core_prec_DO(Core_prec_DO),
    .Core_ready_SI(Core_ready_SI), .Core_done_SI(Core_done_SI),
    .Core_mant_z_DI(Core_mant_z_DI), .Core_exp_z_DI(Core_exp_z_DI),
    .Out_valid_SO(Out_valid_SO), .Out_ready_SI(Out_ready_SI),
    .Out_mant_z_DO(Out_mant_z_DO), .Out_exp_z_DO(Out_exp_z_DO), .Out_tag_DO(Out_tag_DO),
    .Out_special_SO(Out_special_SO),
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
    .Out_err_SO(Out_err_SO),
`endif
    .Out_lat_DO(Out_lat_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int checks = 0, errors = 0, cyc = 0, start_cnt = 0, core_cnt = 0, cur_lat = 0;
  logic [MZW-1:0] cur_mz = '0;
  logic [EZW-1:0] cur_ez = '0;
  exp_t q[$];
  vec_t vec[6];

  always @(posedge Clk_CI) cyc <= cyc + 1;
  always @(negedge Clk_CI) if (Core_start_SO === 1'b1) start_cnt++;

  // Behavioural core: done pulses cur_lat cycles after the start pulse, junk on the result bus otherwise
  always @(negedge Clk_CI) begin
    Core_done_SI = 1'b0;
    Core_mant_z_DI = ~cur_mz;
    Core_exp_z_DI = ~cur_ez;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        Core_done_SI = 1'b1;
        Core_mant_z_DI = cur_mz;
        Core_exp_z_DI = cur_ez;
      end
    end
    if (Core_start_SO === 1'b1 && cur_lat > 0) core_cnt = cur_lat;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.mz = v.sp ? '0 : v.mz;
    e.ez = v.sp ? '0 : v.ez;
    e.tag = v.tag;
    e.sp = v.sp;
    e.lat = v.sp ? 8'd0 : 8'(v.lat);
    return e;
  endfunction

  always begin
    exp_t e;
    @(negedge Clk_CI);
    #2;
    if (Rst_RBI && Out_valid_SO && Out_ready_SI) begin
      if (q.size() == 0) chk("unexpected_out", {63'd0, Out_valid_SO}, 64'd0);
      else begin
        e = q.pop_front();
        chk("out_mant", 64'(Out_mant_z_DO), 64'(e.mz));
        chk("out_exp", 64'(Out_exp_z_DO), 64'(e.ez));
        chk("out_tag", 64'(Out_tag_DO), 64'(e.tag));
        chk("out_special", 64'(Out_special_SO), 64'(e.sp));
        chk("out_lat", 64'(Out_lat_DO), 64'(e.lat));
      end
    end
  end

  task automatic drive(input vec_t v);
    In_div_SI = v.div; In_special_SBI = ~v.sp;
    In_mant_a_DI = v.ma; In_mant_b_DI = v.mb; In_exp_a_DI = v.ea; In_exp_b_DI = v.eb;
    In_tag_DI = v.tag; In_format_DI = v.tag[1:0]; In_prec_DI = 6'(v.tag) + 6'd30;
  endtask

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    drive(v);
    In_valid_SI = 1'b1;
    #1;
    while (!In_ready_SO && n < 200) begin @(negedge Clk_CI); #1; n++; end
    chk("accept_wait", 64'(n < 200), 64'd1);
    @(posedge Clk_CI);
    if (push) q.push_back(mk_exp(v));
    @(negedge Clk_CI);
    In_valid_SI = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!Out_valid_SO && n < lim) begin @(negedge Clk_CI); n++; end
  endtask

  task automatic set_core(input vec_t v);
    cur_lat = v.lat; cur_mz = v.mz; cur_ez = v.ez;
  endtask

  task automatic no_valid(input string nm, input int ncyc);
    int vc = 0;
    repeat (ncyc) begin @(negedge Clk_CI); if (Out_valid_SO) vc++; end
    chk(nm, 64'(vc), 64'd0);
  endtask

  initial begin
    int n, s0;
    vec_t bp, bp2, fv;
    Rst_RBI = 0; Flush_SI = 0; In_valid_SI = 0; Core_ready_SI = 1; Out_ready_SI = 1;
    drive('{0, 0, '0, '0, '0, '0, '0, 0, '0, '0});
    vec[0] = '{1, 0, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 12'h3ff, 12'h3ff, 4'd3, 12, 57'h100_0000_0000_0000, 13'h0ff};
    vec[1] = '{0, 1, 53'h1_2345_6789_abcd, 53'h0, 12'h123, 12'h0, 4'd5, 7, 57'h1abc, 13'h55};
    vec[2] = '{0, 0, 53'h1_8000_0000_0000, 53'h0, 12'h400, 12'h0, 4'd9, 1, 57'h0c0_0000_1111_2222, 13'h1001};
    vec[3] = '{1, 0, 53'h1f_ffff_ffff_ffff, 53'h10_0000_0000_0001, 12'h7fe, 12'h001, 4'd15, 20, 57'h1ff_ffff_ffff_fffe, 13'h1fff};
    vec[4] = '{1, 1, 53'h0a_bcde_f012_3456, 53'h11_1111_1111_1111, 12'h0ff, 12'h800, 4'd0, 4, 57'h123, 13'h7};
    vec[5] = '{0, 0, 53'h15_5555_5555_5555, 53'h0, 12'h3fe, 12'h0, 4'd12, 2, 57'h0aa_5555_0000_ffff, 13'h0800};
    repeat (3) @(negedge Clk_CI);
    #1;
    chk("rst_out_valid", 64'(Out_valid_SO), 64'd0);
    chk("rst_special", 64'(Core_special_SBO), 64'd1);
    chk("rst_special_dly", 64'(Core_special_dly_SBO), 64'd1);
    chk("rst_start", 64'(Core_start_SO), 64'd0);
    chk("rst_kill", 64'(Core_kill_SO), 64'd0);
    chk("rst_lat", 64'(Out_lat_DO), 64'd0);
    Rst_RBI = 1;
    @(negedge Clk_CI);

    foreach (vec[i]) begin
      s0 = start_cnt;
      set_core(vec[i]);
      send(vec[i], 1'b1);
      #1;
      chk("start", 64'(Core_start_SO), 64'(!vec[i].sp));
      chk("div_start", 64'(Core_div_start_SO), 64'(!vec[i].sp && vec[i].div));
      chk("sqrt_start", 64'(Core_sqrt_start_SO), 64'(!vec[i].sp && !vec[i].div));
      chk("op_mant_a", 64'(Core_mant_a_DO), 64'(vec[i].ma));
      chk("op_mant_b", 64'(Core_mant_b_DO), 64'(vec[i].mb));
      chk("op_exp_a", 64'(Core_exp_a_DO), 64'(vec[i].ea));
      chk("op_exp_b", 64'(Core_exp_b_DO), 64'(vec[i].eb));
      chk("op_format", 64'(Core_format_DO), 64'(vec[i].tag[1:0]));
      chk("op_prec", 64'(Core_prec_DO), 64'(6'(vec[i].tag) + 6'd30));
      chk("core_special", 64'(Core_special_SBO), 64'(!vec[i].sp));
      wait_valid(100, n);
      chk("latency", 64'(n + 1), 64'(vec[i].sp ? 1 : vec[i].lat + 2));
      chk("op_stable", 64'(Core_mant_a_DO), 64'(vec[i].ma));
      @(negedge Clk_CI);
      #1;
      chk("special_dly", 64'(Core_special_dly_SBO), 64'(!vec[i].sp));
      chk("start_count", 64'(start_cnt - s0), 64'(vec[i].sp ? 0 : 1));
    end

    // Backpressure in HOLD, then same-cycle re-accept on release
    bp = '{1, 0, 53'h12_3456_789a_bcde, 53'h10_0000_0000_0000, 12'h3ff, 12'h400, 4'd6, 3, 57'h155_aaaa_5555_aaaa, 13'h0abc};
    bp2 = '{0, 0, 53'h19_0000_0000_0000, 53'h0, 12'h401, 12'h0, 4'd7, 2, 57'h0f0_f0f0_f0f0_f0f0, 13'h0321};
    Out_ready_SI = 0;
    set_core(bp);
    send(bp, 1'b1);
    wait_valid(100, n);
    chk("bp_latency", 64'(n + 1), 64'd5);
    drive(bp2);
    In_valid_SI = 1;
    repeat (5) begin
      #1;
      chk("bp_valid", 64'(Out_valid_SO), 64'd1);
      chk("bp_mant", 64'(Out_mant_z_DO), 64'(bp.mz));
      chk("bp_in_ready", 64'(In_ready_SO), 64'd0);
      @(negedge Clk_CI);
    end
    Out_ready_SI = 1;
    set_core(bp2);
    #1;
    chk("release_in_ready", 64'(In_ready_SO), 64'd1);
    @(posedge Clk_CI);
    q.push_back(mk_exp(bp2));
    @(negedge Clk_CI);
    In_valid_SI = 0;
    #1;
    chk("b2b_valid_drop", 64'(Out_valid_SO), 64'd0);
    chk("b2b_sqrt_start", 64'(Core_sqrt_start_SO), 64'd1);
    wait_valid(100, n);
    chk("b2b_latency", 64'(n + 1), 64'd4);
    @(negedge Clk_CI);

    // Flush in BUSY cycle 4: kill pulse next cycle, late done ignored
    fv = '{1, 0, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 12'h3ff, 12'h3ff, 4'd2, 10, 57'h1, 13'h1};
    set_core(fv);
    send(fv, 1'b0);
    repeat (4) @(negedge Clk_CI);
    Flush_SI = 1;
    #1;
    chk("flush_kill_early", 64'(Core_kill_SO), 64'd0);
    @(negedge Clk_CI);
    Flush_SI = 0;
    #1;
    chk("flush_kill", 64'(Core_kill_SO), 64'd1);
    chk("flush_in_ready", 64'(In_ready_SO), 64'd1);
    @(negedge Clk_CI);
    #1;
    chk("flush_kill_once", 64'(Core_kill_SO), 64'd0);
    no_valid("flush_no_valid", 15);

    // Done and flush in the same cycle
    fv = '{0, 0, 53'h18_0000_0000_0000, 53'h0, 12'h3ff, 12'h0, 4'd1, 5, 57'h2, 13'h2};
    set_core(fv);
    send(fv, 1'b0);
    repeat (5) @(negedge Clk_CI);
    #1;
    Flush_SI = 1;
    @(negedge Clk_CI);
    Flush_SI = 0;
    #1;
    chk("done_flush_kill", 64'(Core_kill_SO), 64'd1);
    no_valid("done_flush_no_valid", 10);

    // Asynchronous reset mid-BUSY
    fv = '{1, 0, 53'h1a_0000_0000_0000, 53'h11_0000_0000_0000, 12'h3ff, 12'h3fe, 4'd4, 30, 57'h3, 13'h3};
    set_core(fv);
    send(fv, 1'b0);
    repeat (3) @(negedge Clk_CI);
    #1;
    Rst_RBI = 0;
    #1;
    chk("arst_valid", 64'(Out_valid_SO), 64'd0);
    chk("arst_special", 64'(Core_special_SBO), 64'd1);
    chk("arst_mant_a", 64'(Core_mant_a_DO), 64'd0);
    chk("arst_tag", 64'(Out_tag_DO), 64'd0);
    chk("arst_lat", 64'(Out_lat_DO), 64'd0);
    @(negedge Clk_CI);
    Rst_RBI = 1;
    no_valid("arst_no_valid", 35);

`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
    fv = '{1, 0, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 12'h3ff, 12'h3ff, 4'd11, 0, 57'h0, 13'h0};
    set_core(fv);
    send(fv, 1'b0);
    q.push_back('{'1, '0, 4'd11, 1'b0, 8'd20});
    wait_valid(100, n);
    chk("wd_latency", 64'(n + 1), 64'd22);
    chk("wd_kill", 64'(Core_kill_SO), 64'd1);
    chk("wd_err", 64'(Out_err_SO), 64'd1);
    @(negedge Clk_CI);
    chk("wd_kill_once", 64'(Core_kill_SO), 64'd0);
`endif

    repeat (3) @(negedge Clk_CI);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
